// File: rtl/addr_stack.sv
// ---------------------------------------------------------------------------
// addr_stack
//   Parametrised program-counter / return-address stack. The entry at sp is
//   the live PC. CALL/RSTV push and RET pops by moving the pointer. INC and
//   JMP rewrite the top entry in place. Addresses load byte-wise from the data
//   bus through a low-byte staging register and are read back byte-wise.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset, overrides any op
//   en         op qualifier; en=0 stalls (no state change, no pulses)
//   op         0 NOP, 1 INC, 2 LDLO, 3 JMP, 4 CALL, 5 RET, 6 RSTV, 7 NOP
//   bus_in     data bus byte for LDLO / JMP / CALL
//   vec        restart index for RSTV
//   rd_hi      byte select for bus_out
//   bus_out    combinational byte view of pc (high byte zero-extended)
//   pc         entry[sp]
//   sp         stack pointer
//   used       number of saved return frames, 0..DEPTH-1
//   overflow   one-cycle pulse: CALL/RSTV issued with the stack full
//   underflow  one-cycle pulse: RET issued with no saved frame
//   fault      sticky over/underflow flag (saturating mode only)
// ---------------------------------------------------------------------------
module addr_stack #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned DEPTH      = 8,
  parameter bit          WRAP       = 1'b1,
  parameter int unsigned VEC_SHIFT  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [BUS_WIDTH-1:0]         bus_in,
  input  logic [2:0]                   vec,
  input  logic                         rd_hi,
  output logic [BUS_WIDTH-1:0]         bus_out,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic [$clog2(DEPTH)-1:0]     sp,
  output logic [$clog2(DEPTH)-1:0]     used,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         fault
);

  localparam int unsigned SP_W = $clog2(DEPTH);
  localparam int unsigned HI_W = ADDR_WIDTH - BUS_WIDTH;
  localparam logic [SP_W-1:0] USED_MAX = SP_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INC  = 3'd1,
    OP_LDLO = 3'd2,
    OP_JMP  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_RSTV = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  // Architectural state
  logic [ADDR_WIDTH-1:0] stack_q [DEPTH];
  logic [SP_W-1:0]       sp_q;
  logic [SP_W-1:0]       used_q;
  logic [BUS_WIDTH-1:0]  lo_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  fault_q;

  // Next-state values
  logic [SP_W-1:0]       sp_n;
  logic [SP_W-1:0]       used_n;
  logic [BUS_WIDTH-1:0]  lo_n;
  logic                  ovf_n;
  logic                  unf_n;
  logic                  fault_n;
  logic                  wr_en;
  logic [SP_W-1:0]       wr_idx;
  logic [ADDR_WIDTH-1:0] wr_data;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] call_tgt;
  logic [ADDR_WIDTH-1:0] rst_tgt;
  logic [SP_W-1:0]       sp_inc;
  logic [SP_W-1:0]       sp_dec;
  logic                  full;
  logic                  empty;

  // Live PC is whatever entry the pointer selects
  assign pc_q = stack_q[sp_q];

  // Jump/call target: bus supplies the high bits, staged byte the low bits
  assign call_tgt = {bus_in[HI_W-1:0], lo_q};
  assign rst_tgt  = ADDR_WIDTH'(vec) << VEC_SHIFT;

  // DEPTH is a power of two, so natural wrap gives modulo-DEPTH pointers
  assign sp_inc = sp_q + SP_W'(1);
  assign sp_dec = sp_q - SP_W'(1);
  assign full   = (used_q == USED_MAX);
  assign empty  = (used_q == '0);

  // Next-state decode for one qualified op per cycle
  always_comb begin
    sp_n    = sp_q;
    used_n  = used_q;
    lo_n    = lo_q;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    fault_n = fault_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q;
    wr_data = pc_q;

    if (en) begin
      unique case (op_e'(op))
        OP_INC: begin
          wr_en   = 1'b1;
          wr_data = pc_q + ADDR_WIDTH'(1);
        end
        OP_LDLO: begin
          lo_n = bus_in;
        end
        OP_JMP: begin
          wr_en   = 1'b1;
          wr_data = call_tgt;
        end
        OP_CALL, OP_RSTV: begin
          if (full) begin
            ovf_n = 1'b1;
            if (!WRAP) fault_n = 1'b1;
          end else begin
            used_n = used_q + SP_W'(1);
          end
          // Circular mode still pushes, overwriting the oldest frame
          if (WRAP || !full) begin
            sp_n    = sp_inc;
            wr_en   = 1'b1;
            wr_idx  = sp_inc;
            wr_data = (op_e'(op) == OP_RSTV) ? rst_tgt : call_tgt;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_n = 1'b1;
            if (!WRAP) fault_n = 1'b1;
          end else begin
            used_n = used_q - SP_W'(1);
          end
          // Vacated entry is left intact; circular mode exposes a stale PC
          if (WRAP || !empty) begin
            sp_n = sp_dec;
          end
        end
        OP_NOP, OP_RSV: begin
        end
        default: begin
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stack_q[i] <= '0;
      end
      sp_q    <= '0;
      used_q  <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (wr_en) begin
        stack_q[wr_idx] <= wr_data;
      end
      sp_q    <= sp_n;
      used_q  <= used_n;
      lo_q    <= lo_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
      fault_q <= fault_n;
    end
  end

  // Output views of registered state
  assign pc        = pc_q;
  assign sp        = sp_q;
  assign used      = used_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign fault     = fault_q;

  // Byte readout; high byte is zero-extended when HI_W < BUS_WIDTH
  assign bus_out = rd_hi ? BUS_WIDTH'(pc_q[ADDR_WIDTH-1:BUS_WIDTH])
                         : pc_q[BUS_WIDTH-1:0];

endmodule

// File: tb/tb_addr_stack.sv
// ---------------------------------------------------------------------------
// tb_addr_stack
//   Self-checking bench: a circular-mode instance (dut) and a saturating
//   instance (dut0) share all inputs. A vector table covers the normal ops;
//   hand-written sequences cover underflow, overflow and reset priority.
// ---------------------------------------------------------------------------
module tb_addr_stack;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] INC  = 3'd1;
  localparam logic [2:0] LDLO = 3'd2;
  localparam logic [2:0] JMP  = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;
  localparam logic [2:0] RSTV = 3'd6;
  localparam logic [2:0] RSV  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [7:0]  bus_in;
  logic [2:0]  vec;
  logic        rd_hi;

  logic [7:0]  bus_out,  bus_out0;
  logic [13:0] pc,       pc0;
  logic [2:0]  sp,       sp0;
  logic [2:0]  used,     used0;
  logic        overflow, overflow0;
  logic        underflow, underflow0;
  logic        fault,    fault0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addr_stack #(.ADDR_WIDTH(14), .BUS_WIDTH(8), .DEPTH(8), .WRAP(1'b1), .VEC_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .bus_in(bus_in), .vec(vec), .rd_hi(rd_hi),
    .bus_out(bus_out), .pc(pc), .sp(sp), .used(used),
    .overflow(overflow), .underflow(underflow), .fault(fault)
  );

  addr_stack #(.ADDR_WIDTH(14), .BUS_WIDTH(8), .DEPTH(8), .WRAP(1'b0), .VEC_SHIFT(3)) dut0 (
    .clk(clk), .rst(rst), .en(en), .op(op), .bus_in(bus_in), .vec(vec), .rd_hi(rd_hi),
    .bus_out(bus_out0), .pc(pc0), .sp(sp0), .used(used0),
    .overflow(overflow0), .underflow(underflow0), .fault(fault0)
  );

  typedef struct packed {
    logic        en;
    logic [2:0]  op;
    logic [7:0]  bus;
    logic [2:0]  vec;
    logic        rd_hi;
    logic [13:0] pc;
    logic [2:0]  sp;
    logic [2:0]  used;
    logic [7:0]  bo;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(input logic e, input logic [2:0] o, input logic [7:0] b,
                              input logic [2:0] v, input logic r, input logic [13:0] p,
                              input logic [2:0] s, input logic [2:0] u, input logic [7:0] bo);
    vec_t t;
    t.en = e; t.op = o; t.bus = b; t.vec = v; t.rd_hi = r;
    t.pc = p; t.sp = s; t.used = u; t.bo = bo;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge
  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] b,
                      input logic [2:0] v, input logic r);
    en = e; op = o; bus_in = b; vec = v; rd_hi = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = NOP; bus_in = '0; vec = '0; rd_hi = 1'b0;

    tv[0]  = mk(1, INC,  8'h00, 0, 0, 14'h0001, 0, 0, 8'h01);
    tv[1]  = mk(1, INC,  8'h00, 0, 0, 14'h0002, 0, 0, 8'h02);
    tv[2]  = mk(1, INC,  8'h00, 0, 0, 14'h0003, 0, 0, 8'h03);
    tv[3]  = mk(1, LDLO, 8'h34, 0, 0, 14'h0003, 0, 0, 8'h03);
    tv[4]  = mk(1, JMP,  8'hD2, 0, 1, 14'h1234, 0, 0, 8'h12);
    tv[5]  = mk(1, NOP,  8'h00, 0, 0, 14'h1234, 0, 0, 8'h34);
    tv[6]  = mk(1, LDLO, 8'h00, 0, 0, 14'h1234, 0, 0, 8'h34);
    tv[7]  = mk(1, JMP,  8'h01, 0, 1, 14'h0100, 0, 0, 8'h01);
    tv[8]  = mk(1, CALL, 8'h20, 0, 1, 14'h2000, 1, 1, 8'h20);
    tv[9]  = mk(1, RET,  8'h00, 0, 0, 14'h0100, 0, 0, 8'h00);
    tv[10] = mk(1, RSTV, 8'h00, 5, 0, 14'h0028, 1, 1, 8'h28);
    tv[11] = mk(0, INC,  8'h00, 0, 0, 14'h0028, 1, 1, 8'h28);
    tv[12] = mk(0, INC,  8'h00, 0, 0, 14'h0028, 1, 1, 8'h28);
    tv[13] = mk(0, INC,  8'h00, 0, 0, 14'h0028, 1, 1, 8'h28);
    tv[14] = mk(1, RET,  8'h00, 0, 0, 14'h0100, 0, 0, 8'h00);
    tv[15] = mk(1, LDLO, 8'hFF, 0, 0, 14'h0100, 0, 0, 8'h00);
    tv[16] = mk(1, JMP,  8'h3F, 0, 1, 14'h3FFF, 0, 0, 8'h3F);
    tv[17] = mk(1, INC,  8'h00, 0, 0, 14'h0000, 0, 0, 8'h00);
    tv[18] = mk(1, JMP,  8'hFF, 0, 0, 14'h3FFF, 0, 0, 8'hFF);
    tv[19] = mk(1, RSV,  8'h55, 0, 1, 14'h3FFF, 0, 0, 8'h3F);

    // Reset state
    step(0, NOP, 8'h00, 0, 0);
    step(0, NOP, 8'h00, 0, 0);
    rst = 1'b0;
    chk("reset_pc",      32'(pc),      32'h0);
    chk("reset_bus_out", 32'(bus_out), 32'h0);
    chk("reset_sp",      32'(sp),      32'h0);
    chk("reset_used",    32'(used),    32'h0);
    chk("reset_flags",   32'({overflow, underflow, fault}), 32'h0);
    chk("reset_fault0",  32'(fault0),  32'h0);

    // Table-driven normal ops; no boundary is hit, so both instances agree
    for (int i = 0; i < 20; i++) begin
      step(tv[i].en, tv[i].op, tv[i].bus, tv[i].vec, tv[i].rd_hi);
      chk($sformatf("tv%0d_pc", i),      32'(pc),      32'(tv[i].pc));
      chk($sformatf("tv%0d_sp", i),      32'(sp),      32'(tv[i].sp));
      chk($sformatf("tv%0d_used", i),    32'(used),    32'(tv[i].used));
      chk($sformatf("tv%0d_bus_out", i), 32'(bus_out), 32'(tv[i].bo));
      chk($sformatf("tv%0d_flags", i),   32'({overflow, underflow, fault}), 32'h0);
      chk($sformatf("tv%0d_pc0", i),     32'(pc0),     32'(tv[i].pc));
    end

    // RET with no saved frame
    step(1, RET, 8'h00, 0, 0);
    chk("unf_wrap_pulse", 32'(underflow),  32'h1);
    chk("unf_wrap_sp",    32'(sp),         32'h7);
    chk("unf_wrap_used",  32'(used),       32'h0);
    chk("unf_wrap_pc",    32'(pc),         32'h0);
    chk("unf_wrap_fault", 32'(fault),      32'h0);
    chk("unf_sat_pulse",  32'(underflow0), 32'h1);
    chk("unf_sat_fault",  32'(fault0),     32'h1);
    chk("unf_sat_sp",     32'(sp0),        32'h0);
    chk("unf_sat_pc",     32'(pc0),        32'h3FFF);
    step(1, NOP, 8'h00, 0, 0);
    chk("unf_wrap_drop",  32'(underflow),  32'h0);
    chk("unf_sat_drop",   32'(underflow0), 32'h0);
    chk("unf_sat_sticky", 32'(fault0),     32'h1);
    rst = 1'b1;
    step(0, NOP, 8'h00, 0, 0);
    rst = 1'b0;
    chk("rst_clears_fault0", 32'(fault0), 32'h0);

    // Fill the stack: CALL i targets i<<8
    step(1, LDLO, 8'h00, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1, CALL, 8'(i), 0, 0);
      chk($sformatf("call%0d_sp", i),   32'(sp),   32'(i));
      chk($sformatf("call%0d_used", i), 32'(used), 32'(i));
      chk($sformatf("call%0d_pc", i),   32'(pc),   32'(i) << 8);
      chk($sformatf("call%0d_sp0", i),  32'(sp0),  32'(i));
      chk($sformatf("call%0d_ovf", i),  32'({overflow, overflow0}), 32'h0);
    end
    step(1, CALL, 8'h08, 0, 0);
    chk("ovf_wrap_pulse", 32'(overflow),  32'h1);
    chk("ovf_wrap_sp",    32'(sp),        32'h0);
    chk("ovf_wrap_used",  32'(used),      32'h7);
    chk("ovf_wrap_pc",    32'(pc),        32'h0800);
    chk("ovf_wrap_fault", 32'(fault),     32'h0);
    chk("ovf_sat_pulse",  32'(overflow0), 32'h1);
    chk("ovf_sat_sp",     32'(sp0),       32'h7);
    chk("ovf_sat_used",   32'(used0),     32'h7);
    chk("ovf_sat_pc",     32'(pc0),       32'h0700);
    chk("ovf_sat_fault",  32'(fault0),    32'h1);
    step(1, NOP, 8'h00, 0, 0);
    chk("ovf_wrap_drop",  32'(overflow),  32'h0);
    chk("ovf_sat_drop",   32'(overflow0), 32'h0);
    chk("ovf_sat_sticky", 32'(fault0),    32'h1);
    // Fault does not block later ops
    step(1, INC, 8'h00, 0, 0);
    chk("post_ovf_inc_wrap", 32'(pc),  32'h0801);
    chk("post_ovf_inc_sat",  32'(pc0), 32'h0701);
    step(1, RET, 8'h00, 0, 0);
    chk("post_ovf_ret_wrap_sp",   32'(sp),    32'h7);
    chk("post_ovf_ret_wrap_used", 32'(used),  32'h6);
    chk("post_ovf_ret_wrap_pc",   32'(pc),    32'h0700);
    chk("post_ovf_ret_sat_sp",    32'(sp0),   32'h6);
    chk("post_ovf_ret_sat_pc",    32'(pc0),   32'h0600);
    chk("post_ovf_sat_fault",     32'(fault0), 32'h1);

    // Reset wins over a simultaneous CALL
    rst = 1'b1;
    step(1, CALL, 8'h20, 0, 0);
    rst = 1'b0;
    chk("rst_call_sp",     32'(sp),     32'h0);
    chk("rst_call_pc",     32'(pc),     32'h0);
    chk("rst_call_used",   32'(used),   32'h0);
    chk("rst_call_fault0", 32'(fault0), 32'h0);
    chk("rst_call_sp0",    32'(sp0),    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
